// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the arbiter state encoding, the default watchdog limit and a width helper.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int DEF_TIMEOUT = 4096;

    // Index width that never collapses to zero bits, even for two requesters.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// The winner is only meaningful when any_valid_o is high.
module rr_pick
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PW      = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [PW-1:0]      winner_o,
    output logic               any_valid_o
);

    // Scan offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        winner_o = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((j == ((int'(ptr_i) + off) % NUM_REQ)) && req_i[j]) begin
                    winner_o = PW'(j);
                end
            end
        end
    end

    assign any_valid_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers,
// with a watchdog that aborts frames whose donetx never arrives.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
    parameter int ERR_W          = 16,
    localparam int GW            = clog2_min1(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 send,
    output logic [7:0]           dintx,
    input  logic                 donetx,
    output logic                 busy,
    output logic [GW-1:0]        grant_id,
    output logic                 err_timeout,
    output logic [ERR_W-1:0]     err_count
);

    localparam int WDW = clog2_min1(TIMEOUT_CYCLES);

    arb_state_t           state_q;
    logic                 send_q;
    logic [7:0]           dintx_q;
    logic [NUM_REQ-1:0]   ready_q;
    logic                 busy_q;
    logic [GW-1:0]        grant_q;
    logic [GW-1:0]        ptr_q;
    logic                 err_pulse_q;
    logic [ERR_W-1:0]     err_cnt_q;
    logic                 donetx_q;
    logic [WDW-1:0]       wdog_q;

    logic [GW-1:0]        winner;
    logic                 any_valid;
    logic [GW-1:0]        ptr_d;
    logic [ERR_W-1:0]     err_cnt_d;
    logic [NUM_REQ-1:0]   ready_d;
    logic [7:0]           byte_d;
    logic                 done_rise;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (GW)
    ) u_pick (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .winner_o    (winner),
        .any_valid_o (any_valid)
    );

    always_comb begin
        byte_d = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == GW'(i)) begin
                byte_d = req_data[i*8 +: 8];
            end
        end
    end

    assign done_rise = donetx & ~donetx_q;
    assign ptr_d     = (winner == GW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
    assign ready_d   = NUM_REQ'(1) << winner;

    // Success is tested before the watchdog so a done edge on the last allowed cycle is not an abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            send_q      <= 1'b0;
            dintx_q     <= 8'h00;
            ready_q     <= '0;
            busy_q      <= 1'b0;
            grant_q     <= '0;
            ptr_q       <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            donetx_q    <= 1'b0;
            wdog_q      <= '0;
        end else begin
            donetx_q    <= donetx;
            ready_q     <= '0;
            err_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        dintx_q <= byte_d;
                        grant_q <= winner;
                        ready_q <= ready_d;
                        send_q  <= 1'b1;
                        wdog_q  <= '0;
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (done_rise) begin
                        send_q  <= 1'b0;
                        state_q <= DRAIN;
                    end else if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                        send_q      <= 1'b0;
                        err_pulse_q <= 1'b1;
                        err_cnt_q   <= err_cnt_d;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!donetx_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    send_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign send        = send_q;
    assign dintx       = dintx_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign err_timeout = err_pulse_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter; the bench plays the transmitter and
// predicts each frame from the round-robin and watchdog rules.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int T  = 64;
    localparam int EW = 2;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   reqValid;
    logic [31:0]  reqData;
    logic [3:0]   reqReady;
    logic         send;
    logic [7:0]   dintx;
    logic         donetx;
    logic         busy;
    logic [1:0]   grantId;
    logic         errTimeout;
    logic [EW-1:0] errCount;

    int nCompared   = 0;
    int nMismatched = 0;
    int mPtr        = 0;
    int mErr        = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (T),
        .ERR_W          (EW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (reqValid),
        .req_data    (reqData),
        .req_ready   (reqReady),
        .send        (send),
        .dintx       (dintx),
        .donetx      (donetx),
        .busy        (busy),
        .grant_id    (grantId),
        .err_timeout (errTimeout),
        .err_count   (errCount)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first pending requester at or after the pointer, wrapping.
    function automatic int pickExpected(input logic [3:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // One frame: present v/d, expect a grant next edge; donetx rises on edge k
    // (k > T means never, so the watchdog must abort) and stays high for h edges.
    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input int k, input int h);
        int         w;
        logic [7:0] b;
        logic [3:0] expReady;
        w = pickExpected(v, mPtr);
        reqValid = v;
        reqData  = d;
        nextCycle();
        b = d[w*8 +: 8];
        expReady = 4'(1 << w);
        checkOutput("ready_grant", reqReady, expReady);
        checkOutput("grant_id", grantId, w);
        checkOutput("dintx", dintx, b);
        checkOutput("send_on", send, 1);
        checkOutput("busy_on", busy, 1);
        mPtr = (w + 1) % N;
        if (k == 1) donetx = 1'b1;
        for (int c = 1; c <= T; c++) begin
            nextCycle();
            if (c == 1) reqValid = '0;
            if (c == k) begin
                checkOutput("send_done", send, 0);
                checkOutput("busy_drain", busy, 1);
                checkOutput("no_err_on_done", errTimeout, 0);
                checkOutput("errcnt_kept", errCount, mErr);
                break;
            end
            if (c == T) begin
                mErr = (mErr < ERR_MAX) ? mErr + 1 : ERR_MAX;
                checkOutput("send_abort", send, 0);
                checkOutput("err_pulse", errTimeout, 1);
                checkOutput("err_count", errCount, mErr);
                checkOutput("busy_abort", busy, 0);
                nextCycle();
                checkOutput("err_pulse_end", errTimeout, 0);
                return;
            end
            checkOutput("send_hold", send, 1);
            checkOutput("ready_once", reqReady, 0);
            if (c == k - 1) donetx = 1'b1;
        end
        for (int j = 1; j < h; j++) begin
            nextCycle();
            checkOutput("drain_busy", busy, 1);
            checkOutput("drain_send", send, 0);
        end
        donetx = 1'b0;
        nextCycle();
        checkOutput("drain_hold", busy, 1);
        nextCycle();
        checkOutput("idle_again", busy, 0);
        checkOutput("idle_send", send, 0);
    endtask

    initial begin
        logic [3:0] v;
        int         sel;
        int         k;
        reqValid = '0;
        reqData  = '0;
        donetx   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_send", send, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", reqReady, 0);
        checkOutput("rst_dintx", dintx, 0);
        checkOutput("rst_grant", grantId, 0);
        checkOutput("rst_errpulse", errTimeout, 0);
        checkOutput("rst_errcnt", errCount, 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("idle_noreq_send", send, 0);
            checkOutput("idle_noreq_busy", busy, 0);
        end

        for (int i = 0; i < 4; i++) applyStimulus(4'hF, 32'h43322110, 5 + i, 2);
        applyStimulus(4'b0100, 32'h00A50000, 12, 1);
        for (int i = 0; i < 6; i++) applyStimulus(4'b1001, $urandom, $urandom_range(1, 15), $urandom_range(1, 3));
        for (int i = 0; i < 5; i++) applyStimulus(4'($urandom_range(1, 15)), $urandom, T + 1, 1);
        applyStimulus(4'b0011, $urandom, T, 2);

        reqValid = 4'b0010;
        reqData  = $urandom;
        nextCycle();
        reqValid = '0;
        repeat (20) nextCycle();
        checkOutput("pre_reset_send", send, 1);
        rst = 1'b0;
        #1;
        checkOutput("async_send", send, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_ready", reqReady, 0);
        checkOutput("async_errcnt", errCount, 0);
        checkOutput("async_grant", grantId, 0);
        mPtr = 0;
        mErr = 0;
        nextCycle();
        rst = 1'b1;
        applyStimulus(4'b1010, 32'hDEADBEEF, 8, 2);

        for (int i = 0; i < 40; i++) begin
            v   = 4'($urandom_range(1, 15));
            sel = $urandom_range(0, 9);
            if (sel == 0)      k = T;
            else if (sel == 1) k = T + 1;
            else               k = $urandom_range(1, 20);
            applyStimulus(v, $urandom, k, $urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
